fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port i_stall  input  1  hazard-detector hold request; 1 = hold PC and IF/ID.
REQ-004 SHALL have port i_flush  input  1  branch/jump taken in ID; 1 = redirect PC and squash IF/ID.
REQ-005 SHALL have port i_branch_target  input  32  redirect address, valid when i_flush=1.
REQ-006 SHALL have port i_instr  input  32  instruction-memory read data for address o_pc, same cycle.
REQ-007 SHALL have port i_run  input  1  debug unit: continuous execution level.
REQ-008 SHALL have port i_step  input  1  debug unit: one-cycle pulse requesting a single pipeline advance.
REQ-009 SHALL have port o_pc  output  32  current fetch address.
REQ-010 SHALL have port o_if_id_instr  output  32  IF/ID instruction register.
REQ-011 SHALL have port o_if_id_pc4  output  32  IF/ID PC+4 register.
REQ-012 SHALL have port o_halted  output  1  1 while in HALT state.
REQ-013 SHALL have port o_step_done  output  1  one-cycle pulse after a single step completes.
REQ-014 SHALL have port o_cycle_count  output  32  count of advancing cycles since reset.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, STEP, HALT; reset state IDLE.
REQ-016 SHALL transition IDLE->RUN when i_run=1; IDLE->STEP when i_run=0 and i_step=1; RUN->IDLE when i_run=0; STEP->IDLE unconditionally after one cycle.
REQ-017 SHALL define advance = (state==RUN or state==STEP); no PC, IF/ID or counter update when advance=0.
REQ-018 SHALL, on advance with i_flush=1, load PC<=i_branch_target, IF/ID instr<=NOP (32'h0), IF/ID pc4<=PC+4, regardless of i_stall (flush wins).
REQ-019 SHALL, on advance with i_flush=0 and i_stall=1, hold PC and both IF/ID registers unchanged.
REQ-020 SHALL, on advance with i_flush=0 and i_stall=0, load PC<=PC+4, IF/ID instr<=i_instr, IF/ID pc4<=PC+4.
REQ-021 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-022 SHALL, on an advance per REQ-020 where i_instr[31:26]==HALT_OPCODE (6'b111111), latch the HALT word into IF/ID, hold PC, and enter HALT (HALT overrides the next-state rules of REQ-016).
REQ-023 SHALL, in HALT, hold PC, load NOP into IF/ID instr every cycle, assert o_halted, ignore i_run/i_step/i_stall/i_flush; exit only by reset.
REQ-024 SHALL assert o_step_done for exactly the cycle after STEP (i.e., first cycle back in IDLE), also when the step stalled; not when the step entered HALT.
REQ-025 SHALL increment o_cycle_count by 1 on every advancing cycle (including stalled/flushed ones), wrapping modulo 2^32, frozen in IDLE and HALT.
REQ-026 SHALL ignore i_step while in RUN or STEP.

Reset
REQ-027 SHALL, while i_rst_n=0, force o_pc=32'h0, o_if_id_instr=32'h0, o_if_id_pc4=32'h0, o_halted=0, o_step_done=0, o_cycle_count=0, state=IDLE, asynchronously.
REQ-028 SHALL resume from IDLE on the first rising edge after i_rst_n deasserts; reset mid-RUN or mid-HALT discards all state.

Structure
REQ-029 SHALL take NOP_INSTR, HALT_OPCODE, PC_RESET_VALUE and the FSM state encoding from the shared package mips_pkg.
REQ-030 SHALL isolate the IDLE/RUN/STEP/HALT FSM and o_step_done in one sub-module fetch_fsm emitting advance and halt_enter; PC and IF/ID registers stay in fetch_ctrl.

Verification
REQ-031 SHALL cover: reset, i_run=1, i_instr=32'h2001_0005 for 3 cycles -> o_pc 4,8,12; o_if_id_pc4 4,8,12; o_cycle_count=3.
REQ-032 SHALL cover: RUN at o_pc=8, i_stall=1 for 1 cycle -> o_pc stays 8, IF/ID unchanged, o_cycle_count still increments; next cycle o_pc=12.
REQ-033 SHALL cover: RUN, i_flush=1 and i_stall=1 same cycle, i_branch_target=32'h40 -> o_pc=32'h40, o_if_id_instr=32'h0.
REQ-034 SHALL cover: IDLE, i_step pulse -> exactly one advance (o_pc 0->4), o_step_done=1 for one cycle, then IDLE with o_pc=4 held.
REQ-035 SHALL cover: RUN, i_instr=32'hFC00_0000 at o_pc=16 -> o_if_id_instr=32'hFC00_0000 one cycle then 32'h0, o_pc=16 held, o_halted=1; i_step/i_run ignored until i_rst_n=0.
REQ-036 SHALL cover: o_pc=32'hFFFF_FFFC, advance -> o_pc=32'h0, o_if_id_pc4=32'h0; assert i_rst_n=0 mid-RUN -> all outputs zero immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE    = 6'b111111;
  localparam logic [31:0] PC_RESET_VALUE = 32'h0000_0000;
  localparam logic [31:0] PC_INCR        = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  // True when the word carries the halt opcode in its major opcode field.
  function automatic logic is_halt_instr(input logic [31:0] instr);
    return instr[31:26] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_fsm.sv
// Debug-control sequencer for the fetch stage: decides which cycles advance
// the pipeline and parks the machine in HALT once a halt word is fetched.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | pipeline frozen, waiting for run level or step pulse
// RUN     | advancing every cycle while run is held high
// STEP    | exactly one advancing cycle, then back to IDLE
// HALT    | halt word fetched; frozen until reset
module fetch_fsm
  import mips_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_step,
  input  logic i_stall,
  input  logic i_flush,
  input  logic i_instr_is_halt,
  output logic o_advance,
  output logic o_halt_enter,
  output logic o_halted,
  output logic o_step_done
);

  fetch_state_t state;

  // Advance is a pure decode of the state register; a halt is only taken on
  // a normal (not stalled, not flushed) fetch so a squashed halt word is ignored.
  assign o_advance    = (state == ST_RUN) || (state == ST_STEP);
  assign o_halt_enter = o_advance && !i_flush && !i_stall && i_instr_is_halt;

  // State register with registered halted / step-done flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_halted    <= 1'b0;
      o_step_done <= 1'b0;
    end else begin
      o_step_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_run) begin
            state <= ST_RUN;
          end else if (i_step) begin
            state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (o_halt_enter) begin
            state    <= ST_HALT;
            o_halted <= 1'b1;
          end else if (!i_run) begin
            state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (o_halt_enter) begin
            state    <= ST_HALT;
            o_halted <= 1'b1;
          end else begin
            state       <= ST_IDLE;
            o_step_done <= 1'b1;
          end
        end
        ST_HALT: begin
          o_halted <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          o_halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: program counter, IF/ID pipeline register and
// advancing-cycle counter, gated by the debug sequencer in fetch_fsm.
module fetch_ctrl
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_instr,
  input  logic        i_run,
  input  logic        i_step,
  output logic [31:0] o_pc,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc4,
  output logic        o_halted,
  output logic        o_step_done,
  output logic [31:0] o_cycle_count
);

  logic        advance;
  logic        halt_enter;
  logic [31:0] pc_plus4;

  // Natural 32-bit add; the top word wraps back to address zero.
  assign pc_plus4 = o_pc + PC_INCR;

  fetch_fsm u_fsm (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_run           (i_run),
    .i_step          (i_step),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_instr_is_halt (is_halt_instr(i_instr)),
    .o_advance       (advance),
    .o_halt_enter    (halt_enter),
    .o_halted        (o_halted),
    .o_step_done     (o_step_done)
  );

  // PC and IF/ID update; flush outranks stall, halt holds the PC on the
  // fetch of the halt word, and HALT keeps feeding bubbles into IF/ID.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc          <= PC_RESET_VALUE;
      o_if_id_instr <= NOP_INSTR;
      o_if_id_pc4   <= 32'h0;
    end else if (advance) begin
      if (i_flush) begin
        o_pc          <= i_branch_target;
        o_if_id_instr <= NOP_INSTR;
        o_if_id_pc4   <= pc_plus4;
      end else if (!i_stall) begin
        o_if_id_instr <= i_instr;
        o_if_id_pc4   <= pc_plus4;
        if (!halt_enter) begin
          o_pc <= pc_plus4;
        end
      end
    end else if (o_halted) begin
      o_if_id_instr <= NOP_INSTR;
    end
  end

  // Advancing-cycle counter, including stalled and flushed cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cycle_count <= 32'h0;
    end else if (advance) begin
      o_cycle_count <= o_cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_branch_target;
  logic [31:0] i_instr;
  logic        i_run;
  logic        i_step;
  logic [31:0] o_pc;
  logic [31:0] o_if_id_instr;
  logic [31:0] o_if_id_pc4;
  logic        o_halted;
  logic        o_step_done;
  logic [31:0] o_cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic        use_mem = 1'b0;
  logic [31:0] instr_fixed = 32'h2001_0005;
  logic [31:0] mem [256];
  logic        chk_on = 1'b0;

  // Model: mode 0=frozen, 1=running, 2=single step, 3=halted.
  int          m_mode = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ii = 32'h0;
  logic [31:0] m_p4 = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_sd = 1'b0;

  fetch_ctrl dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_branch_target (i_branch_target),
    .i_instr         (i_instr),
    .i_run           (i_run),
    .i_step          (i_step),
    .o_pc            (o_pc),
    .o_if_id_instr   (o_if_id_instr),
    .o_if_id_pc4     (o_if_id_pc4),
    .o_halted        (o_halted),
    .o_step_done     (o_step_done),
    .o_cycle_count   (o_cycle_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Instruction memory answers for the current fetch address.
  always_comb begin
    i_instr = use_mem ? mem[o_pc[9:2]] : instr_fixed;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what one clock edge does to the visible state.
  always @(posedge i_clk or negedge i_rst_n) begin
    logic [31:0] w;
    logic        was_step;
    if (!i_rst_n) begin
      m_mode = 0; m_pc = 0; m_ii = 0; m_p4 = 0; m_cnt = 0; m_sd = 0;
    end else begin
      w = use_mem ? mem[m_pc[9:2]] : instr_fixed;
      m_sd = 1'b0;
      if (m_mode == 0) begin
        if (i_run) m_mode = 1;
        else if (i_step) m_mode = 2;
      end else if (m_mode == 3) begin
        m_ii = 32'h0;
      end else begin
        was_step = (m_mode == 2);
        m_cnt = m_cnt + 1;
        if (i_flush) begin
          m_p4 = m_pc + 4;
          m_ii = 32'h0;
          m_pc = i_branch_target;
        end else if (!i_stall) begin
          m_p4 = m_pc + 4;
          m_ii = w;
          if (w[31:26] == 6'h3f) m_mode = 3;
          else m_pc = m_pc + 4;
        end
        if (m_mode != 3) begin
          if (was_step) begin
            m_mode = 0;
            m_sd = 1'b1;
          end else if (!i_run) begin
            m_mode = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("pc", o_pc, m_pc);
      chk("if_id_instr", o_if_id_instr, m_ii);
      chk("if_id_pc4", o_if_id_pc4, m_p4);
      chk("cycle_count", o_cycle_count, m_cnt);
      chk("halted", {31'h0, o_halted}, {31'h0, m_mode == 3});
      chk("step_done", {31'h0, o_step_done}, {31'h0, m_sd});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    int halt_cycles;
    i_rst_n = 1'b0;
    i_stall = 0; i_flush = 0; i_branch_target = 0; i_run = 0; i_step = 0;
    #1 chk_on = 1'b1;
    #11;
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_ii", o_if_id_instr, 32'h0);
    chk("rst_cnt", o_cycle_count, 32'h0);
    tick();
    i_rst_n = 1'b1;
    i_run = 1'b1;
    tick();
    chk("run_enter_pc", o_pc, 32'h0);
    tick();
    chk("run1_pc", o_pc, 32'h4);
    chk("run1_pc4", o_if_id_pc4, 32'h4);
    chk("run1_ii", o_if_id_instr, 32'h2001_0005);
    tick();
    chk("run2_pc", o_pc, 32'h8);
    i_stall = 1'b1;
    tick();
    chk("stall_pc", o_pc, 32'h8);
    chk("stall_pc4", o_if_id_pc4, 32'h8);
    chk("stall_cnt", o_cycle_count, 32'd3);
    i_stall = 1'b0;
    tick();
    chk("post_stall_pc", o_pc, 32'hC);
    chk("post_stall_pc4", o_if_id_pc4, 32'hC);
    i_flush = 1'b1; i_stall = 1'b1; i_branch_target = 32'h40;
    tick();
    chk("flush_pc", o_pc, 32'h40);
    chk("flush_ii", o_if_id_instr, 32'h0);
    chk("flush_pc4", o_if_id_pc4, 32'h10);
    i_flush = 1'b0; i_stall = 1'b0;
    i_run = 1'b0;
    tick();
    tick();
    chk("idle_pc", o_pc, 32'h44);
    chk("idle_cnt", o_cycle_count, 32'd6);

    do_reset();
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("step_wait_pc", o_pc, 32'h0);
    tick();
    chk("step_pc", o_pc, 32'h4);
    chk("step_done_hi", {31'h0, o_step_done}, 32'h1);
    tick();
    chk("step_done_lo", {31'h0, o_step_done}, 32'h0);
    chk("step_hold_pc", o_pc, 32'h4);

    i_run = 1'b1;
    tick();
    i_flush = 1'b1; i_branch_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pre_pc", o_pc, 32'hFFFF_FFFC);
    i_flush = 1'b0;
    tick();
    chk("wrap_pc", o_pc, 32'h0);
    chk("wrap_pc4", o_if_id_pc4, 32'h0);
    i_rst_n = 1'b0;
    #1;
    chk("async_pc", o_pc, 32'h0);
    chk("async_ii", o_if_id_instr, 32'h0);
    chk("async_pc4", o_if_id_pc4, 32'h0);
    chk("async_cnt", o_cycle_count, 32'h0);
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("halt_pre_pc", o_pc, 32'h10);
    instr_fixed = 32'hFC00_0000;
    tick();
    chk("halt_ii", o_if_id_instr, 32'hFC00_0000);
    chk("halt_pc", o_pc, 32'h10);
    chk("halt_flag", {31'h0, o_halted}, 32'h1);
    i_step = 1'b1; i_run = 1'b0; i_flush = 1'b1;
    tick();
    chk("halt_nop", o_if_id_instr, 32'h0);
    i_run = 1'b1; i_step = 1'b0;
    tick();
    tick();
    chk("halt_hold_pc", o_pc, 32'h10);
    chk("halt_cnt", o_cycle_count, 32'd5);
    i_flush = 1'b0;
    i_run = 1'b0;
    do_reset();

    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 39) == 0) w[31:26] = 6'h3f;
      else if (w[31:26] == 6'h3f) w[31:26] = 6'h00;
      mem[i] = w;
    end
    use_mem = 1'b1;
    halt_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_mode == 3) halt_cycles++;
      if (halt_cycles > 6 || $urandom_range(0, 399) == 0) begin
        halt_cycles = 0;
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) i_run = ~i_run;
      i_step = ($urandom_range(0, 7) == 0);
      i_stall = ($urandom_range(0, 3) == 0);
      i_flush = ($urandom_range(0, 7) == 0);
      i_branch_target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 15) == 0) i_branch_target = 32'hFFFF_FFF8;
    end
    tick();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
